// File: rtl/fir_pkg.sv
// Shared FSM encoding, address-width helper and the round/saturate output function.
package fir_pkg;

    typedef logic [1:0] fsm_state_t;

    localparam fsm_state_t ST_IDLE  = 2'd0;
    localparam fsm_state_t ST_MAC   = 2'd1;
    localparam fsm_state_t ST_DRAIN = 2'd2;
    localparam fsm_state_t ST_OUT   = 2'd3;

    typedef struct packed {
        logic               sat;
        logic signed [63:0] val;
    } rs_t;

    function automatic int addr_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Round half up, arithmetic shift, then clamp to a signed out_w range.
    function automatic rs_t round_sat(input logic signed [63:0] acc, input int shift, input int out_w);
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        rs_t                res;
        r = acc;
        if (shift > 0)
            r = r + (64'sd1 <<< (shift - 1));
        r = r >>> shift;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        res.sat = (r > hi) || (r < lo);
        res.val = (r > hi) ? hi : ((r < lo) ? lo : r);
        return res;
    endfunction

endpackage

// File: rtl/fir_mac_dp.sv
// Signed multiply-accumulate: registered product, then sign-extended accumulate.
// Latency: operand to accumulator 2 cycles.
// No backpressure; every op_vld operand is consumed.
module fir_mac_dp #(
    parameter int A_W   = 16,
    parameter int B_W   = 16,
    parameter int ACC_W = 40
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    op_vld,
    input  logic                    clr,
    input  logic signed [A_W-1:0]   a,
    input  logic signed [B_W-1:0]   b,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [A_W+B_W-1:0] prod;
    logic                      prod_vld;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prod     <= '0;
            prod_vld <= 1'b0;
            acc      <= '0;
        end else begin
            prod_vld <= op_vld;
            if (op_vld)
                prod <= a * b;
            if (clr)
                acc <= '0;
            else if (prod_vld)
                acc <= acc + {{(ACC_W-A_W-B_W){prod[A_W+B_W-1]}}, prod};
        end
    end

endmodule

// File: rtl/fir_mac_engine.sv
// Time-multiplexed FIR: one sample in, NTAPS MAC cycles, one rounded/saturated result out.
// Latency: out_valid the cycle after edge accept+NTAPS+3.
// sample_ready only in IDLE/OUT; coefficient writes dropped while busy.
module fir_mac_engine
    import fir_pkg::*;
#(
    parameter int NTAPS     = 128,
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int ACC_W     = 40,
    parameter int OUT_W     = 32,
    parameter int OUT_SHIFT = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sample_valid,
    output logic                     sample_ready,
    input  logic [DATA_W-1:0]        sample_in,
    input  logic                     coef_we,
    input  logic [$clog2(NTAPS)-1:0] coef_addr,
    input  logic [COEF_W-1:0]        coef_wdata,
    input  logic                     sat_clr,
    output logic                     out_valid,
    output logic [OUT_W-1:0]         out_data,
    output logic                     busy,
    output logic                     overflow
);

    localparam int                ADDR_W = addr_w(NTAPS);
    localparam logic [ADDR_W:0]   HMAX   = (ADDR_W+1)'(NTAPS);
    localparam logic [ADDR_W-1:0] TLAST  = ADDR_W'(NTAPS - 1);

    if (ACC_W < DATA_W + COEF_W + $clog2(NTAPS)) begin : g_acc_chk
        $error("fir_mac_engine: ACC_W too narrow for DATA_W+COEF_W+clog2(NTAPS)");
    end
    if (ACC_W >= 64 || OUT_W >= 64) begin : g_width_chk
        $error("fir_mac_engine: ACC_W and OUT_W must be below 64");
    end
    if (NTAPS < 4 || (NTAPS & (NTAPS - 1)) != 0) begin : g_ntaps_chk
        $error("fir_mac_engine: NTAPS must be a power of two >= 4");
    end

    fsm_state_t                 state;
    logic [ADDR_W-1:0]          wr_ptr;
    logic [ADDR_W-1:0]          tap;
    logic [ADDR_W:0]            hist_cnt;
    logic [DATA_W-1:0]          ring [NTAPS];
    logic [COEF_W-1:0]          coef [NTAPS];
    logic                       op_vld;
    logic signed [DATA_W-1:0]   op_a;
    logic signed [COEF_W-1:0]   op_b;
    logic signed [ACC_W-1:0]    acc;
    logic [ADDR_W-1:0]          rd_ptr;
    logic                       accept;
    logic [OUT_W-1:0]           out_nxt;
    logic                       sat_nxt;

    assign sample_ready = (state == ST_IDLE) || (state == ST_OUT);
    assign busy         = (state == ST_MAC) || (state == ST_DRAIN);
    assign accept       = sample_valid & sample_ready;
    // Newest sample sits at wr_ptr-1 once the accept has landed.
    assign rd_ptr       = wr_ptr - 1'b1 - tap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            wr_ptr   <= '0;
            tap      <= '0;
            hist_cnt <= '0;
            op_vld   <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
        end else begin
            op_vld <= (state == ST_MAC);
            case (state)
                ST_IDLE, ST_OUT: begin
                    state <= ST_IDLE;
                    if (accept) begin
                        state  <= ST_MAC;
                        tap    <= '0;
                        wr_ptr <= wr_ptr + 1'b1;
                        if (hist_cnt != HMAX)
                            hist_cnt <= hist_cnt + 1'b1;
                    end
                end
                ST_MAC: begin
                    op_a <= ({1'b0, tap} < hist_cnt) ? ring[rd_ptr] : '0;
                    op_b <= coef[tap];
                    tap  <= tap + 1'b1;
                    if (tap == TLAST)
                        state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    // Two cycles: product register, then final accumulate.
                    tap <= tap + 1'b1;
                    if (tap == ADDR_W'(1))
                        state <= ST_OUT;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            ring[wr_ptr] <= sample_in;
        if (coef_we && !busy)
            coef[coef_addr] <= coef_wdata;
    end

    fir_mac_dp #(
        .A_W   (DATA_W),
        .B_W   (COEF_W),
        .ACC_W (ACC_W)
    ) u_dp (
        .clk    (clk),
        .reset  (reset),
        .op_vld (op_vld),
        .clr    (accept),
        .a      (op_a),
        .b      (op_b),
        .acc    (acc)
    );

    always_comb begin
        rs_t r;
        r       = round_sat({{(64-ACC_W){acc[ACC_W-1]}}, acc}, OUT_SHIFT, OUT_W);
        out_nxt = r.val[OUT_W-1:0];
        sat_nxt = r.sat;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            overflow  <= 1'b0;
        end else begin
            out_valid <= (state == ST_OUT);
            if (state == ST_OUT)
                out_data <= out_nxt;
            if (state == ST_OUT && sat_nxt)
                overflow <= 1'b1;
            else if (sat_clr)
                overflow <= 1'b0;
        end
    end

endmodule
